// File: rtl/ppt_sequencer.sv
// Pulsed-plasma-thruster burst sequencer: charge, fire and hold cycles repeated burst_len times,
// with charge timeout fault and abort. All outputs are registered decodes of the next state.
module ppt_sequencer #(
    parameter int PULSE_W = 4,
    parameter int TIMEOUT = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] burst_len,
    input  logic [7:0] period,
    input  logic       charge_ok,
    output logic       charge_en,
    output logic       fire,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [7:0] pulses_left
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHARGE,
        S_FIRE,
        S_HOLD,
        S_DONE,
        S_FAULT
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
    localparam logic [15:0] PULSE_LAST   = 16'(PULSE_W - 1);

    state_t      state_reg, state_next;
    logic [15:0] tmr_reg, tmr_next;
    logic [7:0]  hold_len_reg, hold_len_next;
    logic [7:0]  pulses_reg, pulses_next;
    logic [7:0]  pulses_dec;
    logic        charge_en_reg, fire_reg, busy_reg, done_reg, fault_reg;

    // Saturating decrement; only consulted on the last FIRE edge.
    assign pulses_dec = (pulses_reg == 8'd0) ? 8'd0 : pulses_reg - 8'd1;

    always_comb begin
        state_next    = state_reg;
        tmr_next      = tmr_reg;
        hold_len_next = hold_len_reg;
        pulses_next   = pulses_reg;
        if (abort && state_reg != S_IDLE) begin
            state_next = S_IDLE;
            tmr_next   = '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start && !abort) begin
                        pulses_next   = burst_len;
                        hold_len_next = (period == 8'd0) ? 8'd1 : period;
                        tmr_next      = '0;
                        state_next    = (burst_len == 8'd0) ? S_DONE : S_CHARGE;
                    end
                end
                S_CHARGE: begin
                    // charge_ok outranks the timeout on the same edge.
                    if (charge_ok) begin
                        state_next = S_FIRE;
                        tmr_next   = '0;
                    end else if (tmr_reg == TIMEOUT_LAST) begin
                        state_next = S_FAULT;
                        tmr_next   = '0;
                    end else begin
                        tmr_next = tmr_reg + 16'd1;
                    end
                end
                S_FIRE: begin
                    if (tmr_reg == PULSE_LAST) begin
                        tmr_next    = '0;
                        pulses_next = pulses_dec;
                        state_next  = (pulses_dec == 8'd0) ? S_DONE : S_HOLD;
                    end else begin
                        tmr_next = tmr_reg + 16'd1;
                    end
                end
                S_HOLD: begin
                    if (tmr_reg == {8'd0, hold_len_reg - 8'd1}) begin
                        tmr_next   = '0;
                        state_next = S_CHARGE;
                    end else begin
                        tmr_next = tmr_reg + 16'd1;
                    end
                end
                S_DONE:  state_next = S_IDLE;
                S_FAULT: state_next = S_FAULT;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            tmr_reg       <= '0;
            hold_len_reg  <= '0;
            pulses_reg    <= '0;
            charge_en_reg <= 1'b0;
            fire_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            fault_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            tmr_reg       <= tmr_next;
            hold_len_reg  <= hold_len_next;
            pulses_reg    <= pulses_next;
            charge_en_reg <= (state_next == S_CHARGE);
            fire_reg      <= (state_next == S_FIRE);
            busy_reg      <= (state_next != S_IDLE);
            done_reg      <= (state_next == S_DONE);
            fault_reg     <= (state_next == S_FAULT);
        end
    end

    assign charge_en   = charge_en_reg;
    assign fire        = fire_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign fault       = fault_reg;
    assign pulses_left = pulses_reg;

endmodule

// File: tb/tb_ppt_sequencer.sv
// Bench for ppt_sequencer: per-cycle vector table fed through an expected-output queue,
// then a hand-written asynchronous reset sequence.
module tb_ppt_sequencer;
    localparam int PULSE_W = 4;
    localparam int TIMEOUT = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       charge_ok = 1'b0;
    logic [7:0] burst_len = 8'd0;
    logic [7:0] period = 8'd0;
    logic       charge_en, fire, busy, done, fault;
    logic [7:0] pulses_left;

    ppt_sequencer #(.PULSE_W(PULSE_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .burst_len(burst_len), .period(period), .charge_ok(charge_ok),
        .charge_en(charge_en), .fire(fire), .busy(busy), .done(done),
        .fault(fault), .pulses_left(pulses_left)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       start;
        logic       abort;
        logic [7:0] burst_len;
        logic [7:0] period;
        logic       charge_ok;
    } in_t;

    typedef struct packed {
        logic       charge_en;
        logic       fire;
        logic       busy;
        logic       done;
        logic       fault;
        logic [7:0] pulses_left;
    } out_t;

    typedef struct packed {
        in_t        i;
        out_t       o;
        logic [7:0] scen;
    } vec_t;

    vec_t vecs[$];
    out_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic out_t mk(logic ce, logic f, logic b, logic d, logic flt, logic [7:0] pl);
        out_t r;
        r.charge_en = ce; r.fire = f; r.busy = b; r.done = d; r.fault = flt; r.pulses_left = pl;
        return r;
    endfunction
    function automatic out_t o_idle(logic [7:0] pl);   return mk(0, 0, 0, 0, 0, pl); endfunction
    function automatic out_t o_charge(logic [7:0] pl); return mk(1, 0, 1, 0, 0, pl); endfunction
    function automatic out_t o_fire(logic [7:0] pl);   return mk(0, 1, 1, 0, 0, pl); endfunction
    function automatic out_t o_hold(logic [7:0] pl);   return mk(0, 0, 1, 0, 0, pl); endfunction
    function automatic out_t o_done(logic [7:0] pl);   return mk(0, 0, 1, 1, 0, pl); endfunction
    function automatic out_t o_fault(logic [7:0] pl);  return mk(0, 0, 1, 0, 1, pl); endfunction

    function automatic void add(logic s, logic a, logic [7:0] bl, logic [7:0] pr, logic ok,
                                out_t exp, logic [7:0] scen);
        vec_t v;
        v.i.start = s; v.i.abort = a; v.i.burst_len = bl; v.i.period = pr; v.i.charge_ok = ok;
        v.o = exp;
        v.scen = scen;
        vecs.push_back(v);
    endfunction

    // Expected cycle pattern of a burst with charge_ok held high, derived from the state timing:
    // CHARGE 1, FIRE PULSE_W, HOLD max(period,1), CHARGE 1, ... , DONE 1.
    function automatic void add_burst(logic [7:0] bl, logic [7:0] pr, logic [7:0] scen);
        int hp;
        hp = (pr == 8'd0) ? 1 : int'(pr);
        add(1, 0, bl, pr, 1, o_charge(bl), scen);
        for (int p = int'(bl); p >= 1; p--) begin
            for (int c = 0; c < PULSE_W; c++) add(0, 0, bl, pr, 1, o_fire(8'(p)), scen);
            if (p > 1) begin
                for (int h = 0; h < hp; h++) add(0, 0, bl, pr, 1, o_hold(8'(p - 1)), scen);
                add(0, 0, bl, pr, 1, o_charge(8'(p - 1)), scen);
            end else begin
                add(0, 0, bl, pr, 1, o_done(8'd0), scen);
            end
        end
        add(0, 0, bl, pr, 1, o_idle(8'd0), scen);
    endfunction

    function automatic out_t sample();
        out_t r;
        r = mk(charge_en, fire, busy, done, fault, pulses_left);
        return r;
    endfunction

    task automatic check(string name, out_t got, out_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got ce=%b fire=%b busy=%b done=%b fault=%b left=%0d, required ce=%b fire=%b busy=%b done=%b fault=%b left=%0d",
                     name, got.charge_en, got.fire, got.busy, got.done, got.fault, got.pulses_left,
                     exp.charge_en, exp.fire, exp.busy, exp.done, exp.fault, exp.pulses_left);
        end
    endtask

    initial begin
        out_t exp;
        vec_t v;
        int   k;

        // Scenario 1: basic burst, 3 pulses, period 2
        add_burst(8'd3, 8'd2, 8'd1);
        // Scenario 2: zero-length burst
        add(1, 0, 8'd0, 8'd5, 0, o_done(8'd0), 8'd2);
        add(0, 0, 8'd0, 8'd5, 0, o_idle(8'd0), 8'd2);
        add(0, 0, 8'd0, 8'd5, 0, o_idle(8'd0), 8'd2);
        // Scenario 3: start held high through DONE restarts from the next IDLE edge
        add(1, 0, 8'd0, 8'd1, 0, o_done(8'd0), 8'd3);
        add(1, 0, 8'd0, 8'd1, 0, o_idle(8'd0), 8'd3);
        add(1, 0, 8'd0, 8'd1, 0, o_done(8'd0), 8'd3);
        add(0, 0, 8'd0, 8'd1, 0, o_idle(8'd0), 8'd3);
        // Scenario 4: period 0 behaves as a one-cycle HOLD
        add_burst(8'd2, 8'd0, 8'd4);
        // Scenario 5: abort on the last FIRE edge of the final pulse
        add(1, 0, 8'd2, 8'd1, 1, o_charge(8'd2), 8'd5);
        for (int c = 0; c < PULSE_W; c++) add(0, 0, 8'd2, 8'd1, 1, o_fire(8'd2), 8'd5);
        add(0, 0, 8'd2, 8'd1, 1, o_hold(8'd1), 8'd5);
        add(0, 0, 8'd2, 8'd1, 1, o_charge(8'd1), 8'd5);
        for (int c = 0; c < PULSE_W; c++) add(0, 0, 8'd2, 8'd1, 1, o_fire(8'd1), 8'd5);
        add(0, 1, 8'd2, 8'd1, 1, o_idle(8'd1), 8'd5);
        add(0, 0, 8'd2, 8'd1, 1, o_idle(8'd1), 8'd5);
        // Scenario 6: start with abort in IDLE is ignored
        add(1, 1, 8'd3, 8'd3, 1, o_idle(8'd1), 8'd6);
        // Scenario 7: abort beats charge_ok in CHARGE
        add(1, 0, 8'd1, 8'd1, 0, o_charge(8'd1), 8'd7);
        add(0, 0, 8'd1, 8'd1, 0, o_charge(8'd1), 8'd7);
        add(0, 1, 8'd1, 8'd1, 1, o_idle(8'd1), 8'd7);
        // Scenario 8: abort during HOLD
        add(1, 0, 8'd2, 8'd3, 1, o_charge(8'd2), 8'd8);
        for (int c = 0; c < PULSE_W; c++) add(0, 0, 8'd2, 8'd3, 1, o_fire(8'd2), 8'd8);
        add(0, 0, 8'd2, 8'd3, 1, o_hold(8'd1), 8'd8);
        add(0, 1, 8'd2, 8'd3, 1, o_idle(8'd1), 8'd8);
        // Scenario 9: charge timeout, fault held until abort
        add(1, 0, 8'd1, 8'd1, 0, o_charge(8'd1), 8'd9);
        for (int c = 1; c < TIMEOUT; c++) add(0, 0, 8'd1, 8'd1, 0, o_charge(8'd1), 8'd9);
        add(0, 0, 8'd1, 8'd1, 0, o_fault(8'd1), 8'd9);
        for (int c = 0; c < 3; c++) add(1, 0, 8'd1, 8'd1, 1, o_fault(8'd1), 8'd9);
        add(0, 1, 8'd1, 8'd1, 0, o_idle(8'd1), 8'd9);
        add(0, 0, 8'd1, 8'd1, 0, o_idle(8'd1), 8'd9);
        // Scenario 10: charge_ok arrives on the timeout edge
        add(1, 0, 8'd1, 8'd1, 0, o_charge(8'd1), 8'd10);
        for (int c = 1; c < TIMEOUT; c++) add(0, 0, 8'd1, 8'd1, 0, o_charge(8'd1), 8'd10);
        add(0, 0, 8'd1, 8'd1, 1, o_fire(8'd1), 8'd10);
        for (int c = 1; c < PULSE_W; c++) add(0, 0, 8'd1, 8'd1, 0, o_fire(8'd1), 8'd10);
        add(0, 0, 8'd1, 8'd1, 0, o_done(8'd0), 8'd10);
        add(0, 0, 8'd1, 8'd1, 0, o_idle(8'd0), 8'd10);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", sample(), o_idle(8'd0));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[n]) begin
            v = vecs[n];
            @(negedge clk);
            start = v.i.start; abort = v.i.abort; burst_len = v.i.burst_len;
            period = v.i.period; charge_ok = v.i.charge_ok;
            sb.push_back(v.o);
            @(posedge clk);
            #1;
            exp = sb.pop_front();
            check($sformatf("vec%0d_scen%0d", n, v.scen), sample(), exp);
            n_checks++;
            if (fire && charge_en) begin
                n_fail++;
                $display("FAIL exclusive_vec%0d: fire=%b charge_en=%b both high, required not both",
                         n, fire, charge_en);
            end
        end

        // Asynchronous reset in the middle of a FIRE pulse
        @(negedge clk);
        start = 1'b1; abort = 1'b0; burst_len = 8'd2; period = 8'd1; charge_ok = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (!fire && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("fire_reached", sample(), o_fire(8'd2));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_no_edge", sample(), o_idle(8'd0));
        @(posedge clk);
        #1;
        check("async_reset_held", sample(), o_idle(8'd0));
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1; burst_len = 8'd1; period = 8'd1; charge_ok = 1'b0;
        #1;
        check("after_release", sample(), o_idle(8'd0));
        @(posedge clk);
        #1;
        check("first_start_after_reset", sample(), o_charge(8'd1));
        @(negedge clk);
        start = 1'b0; abort = 1'b1;
        @(posedge clk);
        #1;
        check("final_abort", sample(), o_idle(8'd1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
